// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit. Owns the HI/LO pair, runs
// mult/multu/div/divu as fixed-latency multi-cycle operations and serves
// mfhi/mflo (combinational reads) and mthi/mtlo (registered writes).
//
// Handshake: start is a one-cycle pulse that qualifies mdu_sel 1-4. It is
// accepted only while busy=0 (busy acts as the inverse of ready); a start
// seen while busy=1 is dropped. busy rises at the accepting edge and falls
// at the edge that writes HI/LO, so it is high for exactly N cycles.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  mdu_sel,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [31:0] mdu_out,
  output logic [1:0]  state_dbg
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DIV = 2'd2} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    op_q;
  logic [31:0]   a_q, b_q, hi_q, lo_q;
  logic          accept, finish, op_is_md;
  logic [63:0]   prod_u;
  logic [63:0]   prod_s;
  logic [31:0]   quo_u, rem_u, quo_s, rem_s;

  assign op_is_md  = (mdu_sel >= 4'd1) && (mdu_sel <= 4'd4);
  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;

  // State and cycles-remaining counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state: accept a start in IDLE, count down, finish when counter is 1
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: begin
        if (start && op_is_md) begin
          accept = 1'b1;
          if (mdu_sel <= 4'd2) begin
            state_n = MULT;
            cnt_n   = CW'(MULT_CYCLES);
          end else begin
            state_n = DIV;
            cnt_n   = CW'(DIV_CYCLES);
          end
        end
      end
      MULT, DIV: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = IDLE;
          finish  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand and opcode latches, loaded when an operation is accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else if (accept) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= mdu_sel;
    end
  end

  // Arithmetic on the latched operands; zero divisors are guarded so the
  // dividers never see them (their result is discarded anyway)
  always_comb begin
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    prod_s = $unsigned($signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q}));
    quo_u  = '0;
    rem_u  = '0;
    quo_s  = '0;
    rem_s  = '0;
    if (b_q != 32'd0) begin
      quo_u = a_q / b_q;
      rem_u = a_q % b_q;
      if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
        quo_s = 32'h8000_0000;
        rem_s = 32'd0;
      end else begin
        quo_s = $unsigned($signed(a_q) / $signed(b_q));
        rem_s = $unsigned($signed(a_q) % $signed(b_q));
      end
    end
  end

  // HI/LO: result write on finish, else mthi/mtlo when idle with no start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (finish) begin
      case (op_q)
        4'd1: {hi_q, lo_q} <= prod_s;
        4'd2: {hi_q, lo_q} <= prod_u;
        4'd3: if (b_q != 32'd0) {hi_q, lo_q} <= {rem_s, quo_s};
        4'd4: if (b_q != 32'd0) {hi_q, lo_q} <= {rem_u, quo_u};
        default: ;
      endcase
    end else if (state == IDLE && !start) begin
      if (mdu_sel == 4'd7) hi_q <= a;
      if (mdu_sel == 4'd8) lo_q <= a;
    end
  end

  // mfhi/mflo read port
  always_comb begin
    mdu_out = 32'd0;
    if (mdu_sel == 4'd5) mdu_out = hi_q;
    else if (mdu_sel == 4'd6) mdu_out = lo_q;
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed plus random checks of e_mdu with an expected-result
// queue filled at start and drained when busy falls.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic [3:0]  mdu_sel;
  logic        start;
  logic        busy;
  logic [31:0] hi_out, lo_out, mdu_out;
  logic [1:0]  state_dbg;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(rst_n), .a(a), .b(b), .mdu_sel(mdu_sel), .start(start),
    .busy(busy), .hi_out(hi_out), .lo_out(lo_out), .mdu_out(mdu_out),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference model: products via unsigned multiply with sign correction,
  // signed divide via magnitudes
  function automatic logic [63:0] model(input logic [3:0] sel, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] hi,
                                        input logic [31:0] lo);
    logic [63:0] p;
    logic [31:0] mx, my, q, r;
    case (sel)
      4'd1: begin
        p = {32'd0, x} * {32'd0, y};
        if (x[31]) p = p - {y, 32'd0};
        if (y[31]) p = p - {x, 32'd0};
        return p;
      end
      4'd2: return {32'd0, x} * {32'd0, y};
      4'd3: begin
        if (y == 32'd0) return {hi, lo};
        mx = x[31] ? -x : x;
        my = y[31] ? -y : y;
        q  = mx / my;
        r  = mx % my;
        if (x[31] ^ y[31]) q = -q;
        if (x[31]) r = -r;
        return {r, q};
      end
      4'd4: begin
        if (y == 32'd0) return {hi, lo};
        return {x % y, x / y};
      end
      default: return {hi, lo};
    endcase
  endfunction

  // driver: one operation, busy window checks, scoreboard drain.
  // disturb 1: mthi during busy cycle 2; disturb 2: extra start at cycle 3
  task automatic run_op(input logic [3:0] sel, input logic [31:0] x, input logic [31:0] y,
                        input int n, input int disturb);
    logic [63:0] e;
    exp_q.push_back(model(sel, x, y, m_hi, m_lo));
    mdu_sel = sel; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0; mdu_sel = 4'd5; a = 32'd0; b = 32'd0;
    #1;
    for (int i = 1; i <= n; i++) begin
      check($sformatf("busy_c%0d_op%0d", i, sel), {31'd0, busy}, 32'd1);
      check($sformatf("mfhi_old_c%0d", i), mdu_out, m_hi);
      if (disturb == 1 && i == 2) begin mdu_sel = 4'd7; a = 32'hAAAA_0000; end
      if (disturb == 2 && i == 3) begin start = 1'b1; mdu_sel = 4'd4; a = 32'h1111; b = 32'h2; end
      step();
      start = 1'b0; mdu_sel = 4'd5; a = 32'd0; b = 32'd0;
      #1;
    end
    check($sformatf("busy_done_op%0d", sel), {31'd0, busy}, 32'd0);
    e = exp_q.pop_front();
    check("hi_out", hi_out, e[63:32]);
    check("lo_out", lo_out, e[31:0]);
    check("mfhi_new", mdu_out, e[63:32]);
    mdu_sel = 4'd6;
    #1;
    check("mflo_new", mdu_out, e[31:0]);
    m_hi = e[63:32];
    m_lo = e[31:0];
    mdu_sel = 4'd0;
  endtask

  initial begin
    rst_n = 1'b0; a = 32'd0; b = 32'd0; mdu_sel = 4'd0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi_out, 32'd0);
    check("rst_lo", lo_out, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    check("rst_mdu_out", mdu_out, 32'd0);
    rst_n = 1'b1;
    step();

    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 5, 0);
    check("mult_hi", hi_out, 32'hFFFF_FFFF);
    check("mult_lo", lo_out, 32'hFFFF_FFFA);
    run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 5, 0);
    check("multu_hi", hi_out, 32'h0000_0001);
    check("multu_lo", lo_out, 32'hFFFF_FFFE);
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 10, 0);
    check("div_lo", lo_out, 32'hFFFF_FFFD);
    check("div_hi", hi_out, 32'hFFFF_FFFF);
    run_op(4'd4, 32'd7, 32'd2, 10, 0);
    check("divu_lo", lo_out, 32'd3);
    check("divu_hi", hi_out, 32'd1);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 0);
    check("div_ovf_lo", lo_out, 32'h8000_0000);
    check("div_ovf_hi", hi_out, 32'd0);

    // mthi / mtlo while idle
    mdu_sel = 4'd7; a = 32'h1234;
    step();
    check("mthi", hi_out, 32'h1234);
    mdu_sel = 4'd8; a = 32'h5678;
    step();
    check("mtlo", lo_out, 32'h5678);
    m_hi = 32'h1234; m_lo = 32'h5678;
    mdu_sel = 4'd0; a = 32'd0;

    // divu by zero with an mthi attempt during busy
    run_op(4'd4, 32'd9, 32'd0, 10, 1);
    check("dz_hi", hi_out, 32'h1234);
    check("dz_lo", lo_out, 32'h5678);

    // second start at busy cycle 3 is dropped
    run_op(4'd1, 32'd7, 32'd6, 5, 2);
    check("restart_lo", lo_out, 32'd42);
    check("restart_hi", hi_out, 32'd0);
    check("restart_idle", {31'd0, busy}, 32'd0);

    // start with a non-arith select, and arith select without start
    start = 1'b1; mdu_sel = 4'd9; a = 32'd3; b = 32'd3;
    step();
    check("start_sel9_busy", {31'd0, busy}, 32'd0);
    start = 1'b0; mdu_sel = 4'd3;
    step();
    check("sel3_nostart_busy", {31'd0, busy}, 32'd0);
    check("noeffect_lo", lo_out, 32'd42);
    mdu_sel = 4'd0;

    // back-to-back random operations (each start lands right after busy falls)
    repeat (4) begin
      logic [3:0] s;
      s = 4'($urandom_range(1, 4));
      run_op(s, $urandom, (s >= 4'd3) ? 32'($urandom_range(0, 300)) : $urandom,
             (s <= 4'd2) ? 5 : 10, 0);
    end

    // asynchronous reset at busy cycle 2
    mdu_sel = 4'd1; a = 32'd5; b = 32'd5; start = 1'b1;
    step();
    start = 1'b0; mdu_sel = 4'd0;
    step();
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_hi", hi_out, 32'd0);
    check("async_rst_lo", lo_out, 32'd0);
    #2;
    rst_n = 1'b1;
    repeat (8) step();
    check("post_rst_hi", hi_out, 32'd0);
    check("post_rst_lo", lo_out, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
